pixel_event_arbiter: RTL

Collects pixel-write records from two requesters: the packet generator (brush and symmetry expansion) and the undo/redo buffer (restore events). It arbitrates them into one ordered FIFO that the I2C slave drains one record per host read. It sits between those requesters and the I2C status/position registers. It replaces the direct wiring of packet-generator coordinates to the I2C slave and gives undo/redo restores a path to the host.

---
 rtl/canvas_pkg.sv | 24 ++
 rtl/pixel_fifo.sv | 69 ++++++
 rtl/pixel_event_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/canvas_pkg.sv
// Shared canvas types: pixel record layout, coordinate/colour widths and colour codes.
package canvas_pkg;

    localparam int COORD_W = 8;
    localparam int COLOR_W = 3;

    // Colour encoding is {R,G,B}, one bit per channel
    localparam logic [COLOR_W-1:0] COLOR_BLACK   = 3'b000;
    localparam logic [COLOR_W-1:0] COLOR_BLUE    = 3'b001;
    localparam logic [COLOR_W-1:0] COLOR_GREEN   = 3'b010;
    localparam logic [COLOR_W-1:0] COLOR_CYAN    = 3'b011;
    localparam logic [COLOR_W-1:0] COLOR_RED     = 3'b100;
    localparam logic [COLOR_W-1:0] COLOR_MAGENTA = 3'b101;
    localparam logic [COLOR_W-1:0] COLOR_YELLOW  = 3'b110;
    localparam logic [COLOR_W-1:0] COLOR_WHITE   = 3'b111;

    typedef struct packed {
        logic               is_restore;
        logic [COLOR_W-1:0] color;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pixel_rec_t;

endpackage

// File: rtl/pixel_fifo.sv
// Power-of-two ordered FIFO of pixel records with synchronous flush and registered count.
module pixel_fifo
    import canvas_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  pixel_rec_t                 push_rec,
    input  logic                       pop,
    output pixel_rec_t                 head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    pixel_rec_t             mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic                   push_s;
    logic                   pop_s;

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

    // Qualified push/pop: overfull writes and empty pops are ignored
    always_comb begin
        push_s = push & ~full;
        pop_s  = pop & ~empty;
    end

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_rec;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pixel_event_arbiter.sv
// Merges packet-generator draws and undo/redo restore pulses into one ordered record FIFO
// read by the I2C slave; restores sit in a one-entry skid register with bounded priority.
module pixel_event_arbiter
    import canvas_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int MAX_STREAK = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       draw_valid,
    output logic                       draw_ready,
    input  logic [7:0]                 draw_x,
    input  logic [7:0]                 draw_y,
    input  logic [2:0]                 draw_color,
    input  logic                       rst_pulse,
    input  logic [7:0]                 rst_x,
    input  logic [7:0]                 rst_y,
    input  logic [2:0]                 rst_color,
    output logic                       out_valid,
    output logic [7:0]                 out_x,
    output logic [7:0]                 out_y,
    output logic [2:0]                 out_color,
    output logic                       out_is_restore,
    input  logic                       out_pop,
    input  logic                       flush,
    input  logic                       clr_overflow,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);

    localparam int STREAK_W = $clog2(MAX_STREAK+1);

    logic                pend_r;
    pixel_rec_t          pend_rec_r;
    logic [STREAK_W-1:0] streak_r;
    logic                overflow_r;

    logic                full_s;
    logic                empty_s;
    pixel_rec_t          head_s;
    pixel_rec_t          push_rec_s;
    logic                streak_lt_s;
    logic                grant_rst_s;
    logic                grant_draw_s;
    logic                ready_s;
    logic                drop_s;
    logic                load_s;

    // Arbitration: restores win until the streak limit, then a waiting draw gets one slot
    always_comb begin
        streak_lt_s  = (streak_r < STREAK_W'(MAX_STREAK));
        grant_rst_s  = ~full_s & ~flush & pend_r & (streak_lt_s | ~draw_valid);
        ready_s      = rst_n & ~full_s & ~flush & ~(pend_r & streak_lt_s);
        grant_draw_s = draw_valid & ready_s;
        drop_s       = ~flush & rst_pulse & pend_r & ~grant_rst_s;
        load_s       = rst_pulse & (~pend_r | grant_rst_s);
        if (grant_rst_s) begin
            push_rec_s = pend_rec_r;
        end else begin
            push_rec_s = '{is_restore: 1'b0, color: draw_color, x: draw_x, y: draw_y};
        end
    end

    // Restore skid register; a pulse arriving while the entry is stuck is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r     <= 1'b0;
            pend_rec_r <= '0;
        end else if (flush) begin
            pend_r     <= 1'b0;
        end else if (load_s) begin
            pend_r     <= 1'b1;
            pend_rec_r <= '{is_restore: 1'b1, color: rst_color, x: rst_x, y: rst_y};
        end else if (grant_rst_s) begin
            pend_r     <= 1'b0;
        end else begin
            pend_r     <= pend_r;
        end
    end

    // Consecutive-restore streak, saturating; any draw grant restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_r <= '0;
        end else if (flush) begin
            streak_r <= '0;
        end else if (grant_rst_s && streak_lt_s) begin
            streak_r <= streak_r + STREAK_W'(1);
        end else if (grant_draw_s) begin
            streak_r <= '0;
        end else begin
            streak_r <= streak_r;
        end
    end

    // Sticky overflow; a same-cycle drop beats the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_overflow) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (grant_rst_s | grant_draw_s),
        .push_rec (push_rec_s),
        .pop      (out_pop),
        .head     (head_s),
        .count    (fifo_count),
        .full     (full_s),
        .empty    (empty_s)
    );

    assign draw_ready     = ready_s;
    assign out_valid      = ~empty_s;
    assign out_x          = head_s.x;
    assign out_y          = head_s.y;
    assign out_color      = head_s.color;
    assign out_is_restore = head_s.is_restore;
    assign overflow       = overflow_r;

endmodule
